// File: rtl/hamming_mem_if.sv
// rtl/hamming_mem_if.sv - job request, data-memory bus and status bundle for hamming_mem_engine
//
// Parameters: AW = data-memory address width, CW = status counter width.
// Signals:
//   init, mode, src_base, dst_base, count   job request (driven by the core)
//   mem_addr, mem_wr_en, mem_wdata          data-memory master outputs
//   mem_rdata                               data-memory read data (one cycle after mem_addr)
//   done, corr_cnt, unc_cnt                 job status
// Modports: master = engine side, slave = core/memory side.

interface hamming_mem_if #(
    parameter int AW = 8,
    parameter int CW = 8
);
    logic          init;
    logic          mode;
    logic [AW-1:0] src_base;
    logic [AW-1:0] dst_base;
    logic [AW-1:0] count;
    logic [AW-1:0] mem_addr;
    logic          mem_wr_en;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;
    logic          done;
    logic [CW-1:0] corr_cnt;
    logic [CW-1:0] unc_cnt;

    modport master (
        input  init, mode, src_base, dst_base, count, mem_rdata,
        output mem_addr, mem_wr_en, mem_wdata, done, corr_cnt, unc_cnt
    );

    modport slave (
        output init, mode, src_base, dst_base, count, mem_rdata,
        input  mem_addr, mem_wr_en, mem_wdata, done, corr_cnt, unc_cnt
    );
endinterface

// File: rtl/hamming_mem_engine.sv
// rtl/hamming_mem_engine.sv - Hamming(15,11) memory-to-memory encode/decode engine
//
// Ports: clk, reset_n (async active-low), bus (hamming_mem_if.master).
// Walks `count` 16-bit messages (lo byte at base+2i, hi at base+2i+1), five
// cycles per message: RD_LO, RD_HI, CAP, WR_LO, WR_HI.
// Optional macro HAMMING_DED_EN: SEC-DED with overall parity p0 in hi[7] and
// uncorrectable-event counting; without it, SEC only and unc_cnt stays 0.

module hamming_mem_engine #(
    parameter int AW = 8,
    parameter int CW = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    hamming_mem_if.master  bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RD_LO = 3'd1;
    localparam logic [2:0] S_RD_HI = 3'd2;
    localparam logic [2:0] S_CAP   = 3'd3;
    localparam logic [2:0] S_WR_LO = 3'd4;
    localparam logic [2:0] S_WR_HI = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    // Masks over codeword positions [15:1]: position p is covered by parity 2^k when bit k of p is set.
    localparam logic [15:1] M_P1 = 15'h5555;
    localparam logic [15:1] M_P2 = 15'h6666;
    localparam logic [15:1] M_P4 = 15'h7878;
    localparam logic [15:1] M_P8 = 15'h7F80;

    logic [2:0]    state;
    logic          mode_q;
    logic [AW-1:0] src_q;      // running source pointer, src_base + 2i
    logic [AW-1:0] dst_q;      // running destination pointer, dst_base + 2i
    logic [AW-1:0] cnt_q;
    logic [AW-1:0] idx_q;
    logic [7:0]    lo_q;
    logic [7:0]    hi_q;
    logic [CW-1:0] corr_q;
    logic [CW-1:0] unc_q;

    logic [15:1] enc_d, enc_cw, rx_cw, fix_cw;
    logic [3:0]  syn;
    logic        p0_enc, corr_evt, unc_evt, do_flip;
    logic [15:0] enc_word, dec_word, result;

    always_comb begin
        enc_d         = '0;
        enc_d[3]      = lo_q[0];
        enc_d[7:5]    = lo_q[3:1];
        enc_d[15:9]   = {hi_q[2:0], lo_q[7:4]};
        enc_cw        = enc_d;
        enc_cw[1]     = ^(enc_d & M_P1);
        enc_cw[2]     = ^(enc_d & M_P2);
        enc_cw[4]     = ^(enc_d & M_P4);
        enc_cw[8]     = ^(enc_d & M_P8);

        rx_cw = {hi_q[6:0], lo_q};
        syn   = {^(rx_cw & M_P8), ^(rx_cw & M_P4), ^(rx_cw & M_P2), ^(rx_cw & M_P1)};

`ifdef HAMMING_DED_EN
        p0_enc   = ^enc_cw;
        // Odd overall parity means one flipped bit (possibly p0 itself, when syn == 0);
        // even parity with a nonzero syndrome means two flips, which are left alone.
        corr_evt = ^{hi_q[7], rx_cw};
        unc_evt  = !corr_evt && (syn != 4'd0);
        do_flip  = corr_evt && (syn != 4'd0);
`else
        p0_enc   = 1'b0;
        corr_evt = (syn != 4'd0);
        unc_evt  = 1'b0;
        do_flip  = corr_evt;
`endif

        fix_cw = rx_cw;
        for (int k = 1; k < 16; k++) begin
            if (do_flip && (syn == 4'(k))) fix_cw[k] = ~rx_cw[k];
        end

        enc_word = {p0_enc, enc_cw};
        dec_word = {unc_evt, 4'b0000, fix_cw[15:9], fix_cw[7:5], fix_cw[3]};
        result   = mode_q ? dec_word : enc_word;
    end

    always_comb begin
        bus.mem_addr  = '0;
        bus.mem_wr_en = 1'b0;
        bus.mem_wdata = 8'h00;
        case (state)
            S_RD_LO: bus.mem_addr = src_q;
            S_RD_HI: bus.mem_addr = src_q + AW'(1);
            S_WR_LO: begin
                bus.mem_addr  = dst_q;
                bus.mem_wr_en = 1'b1;
                bus.mem_wdata = result[7:0];
            end
            S_WR_HI: begin
                bus.mem_addr  = dst_q + AW'(1);
                bus.mem_wr_en = 1'b1;
                bus.mem_wdata = result[15:8];
            end
            default: ;
        endcase
    end

    assign bus.done     = (state == S_DONE);
    assign bus.corr_cnt = corr_q;
    assign bus.unc_cnt  = unc_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            mode_q <= 1'b0;
            src_q  <= '0;
            dst_q  <= '0;
            cnt_q  <= '0;
            idx_q  <= '0;
            lo_q   <= 8'h00;
            hi_q   <= 8'h00;
            corr_q <= '0;
            unc_q  <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.init) begin
                        mode_q <= bus.mode;
                        src_q  <= bus.src_base;
                        dst_q  <= bus.dst_base;
                        cnt_q  <= bus.count;
                        idx_q  <= '0;
                        corr_q <= '0;
                        unc_q  <= '0;
                        state  <= (bus.count == '0) ? S_DONE : S_RD_LO;
                    end
                end
                S_RD_LO: state <= S_RD_HI;
                S_RD_HI: begin
                    lo_q  <= bus.mem_rdata;
                    state <= S_CAP;
                end
                S_CAP: begin
                    hi_q  <= bus.mem_rdata;
                    state <= S_WR_LO;
                end
                S_WR_LO: state <= S_WR_HI;
                S_WR_HI: begin
                    if (mode_q && corr_evt && (corr_q != {CW{1'b1}})) corr_q <= corr_q + CW'(1);
                    if (mode_q && unc_evt && (unc_q != {CW{1'b1}}))   unc_q  <= unc_q + CW'(1);
                    src_q <= src_q + AW'(2);
                    dst_q <= dst_q + AW'(2);
                    idx_q <= idx_q + AW'(1);
                    state <= ((idx_q + AW'(1)) == cnt_q) ? S_DONE : S_RD_LO;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/hamming_mem_engine.md
# hamming_mem_engine

Parametrised Hamming(15,11) memory-to-memory engine that runs under the core's `init`/`done` handshake. One request walks `count` 16-bit messages in data memory and runs in one of two modes:
- encode: insert parity into each message;
- decode: compute the syndrome, correct the message and strip parity.

Results go to a destination region, and the engine keeps corrected/uncorrectable event counters. It sits beside the core as a data-memory master and replaces the software loops for the parity programs.

## Interface
- `AW`, 8, data-memory address width; all address arithmetic is modulo 2^AW.
- `CW`, 8, width of the status counters.
- `clk`  in  1  clock; all state changes on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `init`  in  1  start request; sampled only in IDLE.
- `mode`  in  1  0 = encode, 1 = decode; latched when `init` is accepted.
- `src_base`  in  AW  first source byte address; latched at accept.
- `dst_base`  in  AW  first destination byte address; latched at accept.
- `count`  in  AW  number of messages; latched at accept.
- `mem_addr`  out  AW  data-memory address.
- `mem_wr_en`  out  1  write strobe.
- `mem_wdata`  out  8  write data.
- `mem_rdata`  in  8  read data; valid the cycle after `mem_addr` is presented (synchronous read).
- `done`  out  1  high from job completion until the next accepted `init`.
- `corr_cnt`  out  CW  corrected messages in the last job; saturates at all-ones.
- `unc_cnt`  out  CW  uncorrectable messages in the last job (DED build only, otherwise 0); saturates.

## Operation
- Message i occupies byte `base+2i` (low byte) and byte `base+2i+1` (high byte).
- Codeword bit layout: bits 15..9 = d11..d5, 8 = p8, 7..5 = d4..d2, 4 = p4, 3 = d1, 2 = p2, 1 = p1. Codeword bits [15:9] map to hi[6:0]; bits [8:1] map to lo.
- Encode:
  - input is the 11-bit message {hi[2:0], lo};
  - output is {hi[7], codeword}, where hi[7] = 0 in the base build.
- Decode:
  - syndrome = {p8^s8, p4^s4, p2^s2, p1^s1};
  - a nonzero syndrome flips that codeword bit and increments `corr_cnt`;
  - output is {5'b0, d11..d1}.
- States:
  - IDLE: `init` → RD_LO; clears both counters and `done`; latches `mode`, bases and `count`. If `count` = 0, go directly to DONE.
  - RD_LO: `mem_addr` = src+2i.
  - RD_HI: `mem_addr` = src+2i+1; capture lo.
  - CAP: capture hi.
  - WR_LO: write lo to dst+2i.
  - WR_HI: write hi to dst+2i+1; i++. If i = `count`, go to DONE, else RD_LO.
  - DONE: `done` = 1; `init` → behaves as IDLE accept.
- All reads of message i complete before its writes, so in-place operation (src = dst) is legal.
- `init` is ignored while busy; the latched inputs may change freely once a job is running.
- Reset values: state IDLE, `done` = 0, `mem_wr_en` = 0, `mem_addr` = 0, `mem_wdata` = 0, counters 0.
- Reset mid-job aborts immediately with no further writes. Writes already performed remain.

## Timing
- Cycle 0 = edge sampling `init` in IDLE. Message i is in RD_LO at cycle 5i+1 and in WR_HI at cycle 5i+5.
- `done` rises at cycle 5·`count`+1. For `count` = 0, `done` rises at cycle 1.
- `mem_wr_en` is high only in WR_LO and WR_HI, exactly one cycle per byte.
- Counters update at the WR_HI edge and are stable whenever `done` = 1.
- Accepting `init` from DONE drops `done` on the next edge.

## Configuration
- `HAMMING_DED_EN` defined (SEC-DED): extended parity p0 = XOR of codeword bits 15..1.
  - Encode writes p0 into hi[7].
  - Decode also checks overall parity:
    - overall bad, syndrome 0: p0 error → corrected, `corr_cnt`++;
    - overall bad, syndrome ≠ 0: single error → corrected, `corr_cnt`++;
    - overall good, syndrome ≠ 0: double error → no correction, hi[7] = 1, `unc_cnt`++.
- `HAMMING_DED_EN` undefined: SEC only. hi[7] is ignored on input and written as 0; `unc_cnt` is tied to 0.

## Test plan
- Encode, count = 2, data 11'h000 and 11'h7FF at src 0 → dst 30 holds 00,00 and FF,7F (base build) or FF,FF (DED). `done` at cycle 11.
- Decode, count = 1, codeword 0x7FFF with bit 5 flipped (lo EF, hi 7F) → writes FF,07; `corr_cnt` = 1.
- DED decode of FF,FF with bits 3 and 5 flipped (lo EB) → writes FC,87; `unc_cnt` = 1, `corr_cnt` = 0.
- In-place decode, src = dst = 64, count = 15, one random single flip per message → every message restored; `corr_cnt` = number of nonzero flips.
- `count` = 0 → `done` at cycle 1 with no writes. `src_base` = 8'hFE, count = 2 → addresses wrap to 00/01.
- `reset_n` low during WR_LO of message 3 → `mem_wr_en` drops asynchronously and state is IDLE. A subsequent `init` completes normally.
